sweep_arbiter: RTL and testbench
================================

SWEEP_ARBITER -- requirements
Module: sweep_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 4, width of all address ports.
REQ-002 SHALL have port clockSweep  input  1  clock; all state updates on its rising edge.
REQ-003 SHALL have port resetSweep  input  1  reset, synchronous, active-low; sampled on the rising edge of clockSweep.
REQ-004 SHALL have ports reqA, reqB  input  1 each  sweep request from requester A, B.
REQ-005 SHALL have ports startA, startB  input  ADDR_WIDTH each  first address of the requested sweep.
REQ-006 SHALL have ports endA, endB  input  ADDR_WIDTH each  last address of the requested sweep.
REQ-007 SHALL have port readyIn  input  1  downstream accepts the current address beat.
REQ-008 SHALL have port addressSweep  output  ADDR_WIDTH  address currently presented.
REQ-009 SHALL have port validSweep  output  1  addressSweep is a live beat.
REQ-010 SHALL have port ownerSweep  output  1  owner of the current sweep (0 = A, 1 = B).
REQ-011 SHALL have ports grantA, grantB  output  1 each  requester holds the sweeper.
REQ-012 SHALL have ports doneA, doneB  output  1 each  one-cycle sweep-complete pulse.
REQ-013 SHALL have port busySweep  output  1  high in any state other than IDLE.

Function
REQ-014 SHALL implement the states IDLE, SETUP, RUN and DONE, all registered.
REQ-015 IDLE: if any req is high, the block SHALL select a winner, latch that requester's start/end into internal registers, set ownerSweep, and move to SETUP; otherwise it stays in IDLE.
REQ-016 Arbitration SHALL be round-robin: with a single request, that requester wins; with reqA and reqB both high, the requester not served last wins; after reset, "last served" = B, so A wins the first tie.
REQ-017 SETUP SHALL last exactly one cycle, with validSweep low and addressSweep equal to the latched start; it then moves to RUN.
REQ-018 RUN SHALL hold validSweep high; each cycle with readyIn high, the beat is consumed and addressSweep advances by 1 modulo 2^ADDR_WIDTH; with readyIn low, address and valid hold.
REQ-019 RUN SHALL move to DONE when the beat at address == latched end is consumed; validSweep is low in DONE.
REQ-020 If end < start, the sweep SHALL wrap (e.g. 14,15,0,1); if end == start, the sweep SHALL be exactly one beat.
REQ-021 Beat count per sweep SHALL be ((end - start) mod 2^ADDR_WIDTH) + 1.
REQ-022 DONE SHALL last one cycle, pulse doneA or doneB (owner only), update "last served", and return to IDLE.
REQ-023 grantA/grantB SHALL be high only for the owner, throughout SETUP, RUN and DONE, and never both high.
REQ-024 The block SHALL ignore req, start and end inputs outside IDLE; a requester still asserting req in IDLE after its DONE is re-arbitrated normally.
REQ-025 Latency: req high at edge k SHALL give SETUP at k+1 and the first valid beat at k+2.
REQ-026 A requester already in IDLE SHALL NOT be granted a new sweep in the same cycle as DONE; there is a minimum of one IDLE cycle between sweeps.

Reset
REQ-027 When resetSweep is low at an edge, the block SHALL go to IDLE, set addressSweep=0, validSweep=0, ownerSweep=0, grants=0, dones=0, busySweep=0, and "last served"=B, regardless of state.
REQ-028 Reset mid-sweep SHALL abort the sweep with no done pulse.

Verification
REQ-029 reqA=1 with startA=0, endA=15, readyIn=1 -> SETUP at 1 cycle, then 16 valid beats 0..15, doneA pulse at 1 cycle, grantA low afterward.
REQ-030 reqA=reqB=1 from reset (B: start=3, end=5) -> A is served first; B is then granted after one IDLE cycle; beats 3,4,5; doneB pulses.
REQ-031 startB=14, endB=1 -> beats 14,15,0,1; then DONE.
REQ-032 startA=endA=7 -> exactly one beat at address 7; doneA pulses.
REQ-033 readyIn toggling 1,0,0,1 during RUN -> address holds while readyIn is low; no beat is skipped or duplicated.
REQ-034 resetSweep low during RUN at address 9 -> next cycle all outputs are at their reset values, no done pulse, and "last served" is reset to B.

Source files
------------

// File: rtl/sweep_arbiter.sv
// Sweep arbiter: round-robin arbitration between two requesters. The winner
// gets an address sweep from its start address to its end address, one beat
// per downstream handshake. Addresses wrap modulo 2^ADDR_WIDTH.
module sweep_arbiter #(
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clockSweep,
    input  logic                  resetSweep,
    input  logic                  reqA,
    input  logic                  reqB,
    input  logic [ADDR_WIDTH-1:0] startA,
    input  logic [ADDR_WIDTH-1:0] startB,
    input  logic [ADDR_WIDTH-1:0] endA,
    input  logic [ADDR_WIDTH-1:0] endB,
    input  logic                  readyIn,
    output logic [ADDR_WIDTH-1:0] addressSweep,
    output logic                  validSweep,
    output logic                  ownerSweep,
    output logic                  grantA,
    output logic                  grantB,
    output logic                  doneA,
    output logic                  doneB,
    output logic                  busySweep
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SETUP = 2'd1;
    localparam logic [1:0] RUN   = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] r_end;
    logic                  r_owner;
    logic                  r_lastB;

    logic                  w_anyReq;
    logic                  w_pickB;
    logic                  w_beatTaken;
    logic                  w_lastBeat;

    // Arbitration choice and beat bookkeeping, evaluated every cycle
    always_comb begin
        w_anyReq    = reqA | reqB;
        w_pickB     = reqB & (~reqA | ~r_lastB);
        w_beatTaken = (r_state == RUN) & readyIn;
        w_lastBeat  = w_beatTaken & (r_addr == r_end);
    end

    // Sweep state machine; reset aborts any sweep and restores "last served = B"
    always_ff @(posedge clockSweep) begin
        if (!resetSweep) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_end   <= '0;
            r_owner <= 1'b0;
            r_lastB <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_anyReq) begin
                        r_owner <= w_pickB;
                        r_addr  <= w_pickB ? startB : startA;
                        r_end   <= w_pickB ? endB : endA;
                        r_state <= SETUP;
                    end
                end
                SETUP: begin
                    r_state <= RUN;
                end
                RUN: begin
                    if (w_lastBeat) begin
                        r_state <= DONE;
                    end else if (w_beatTaken) begin
                        r_addr <= r_addr + 1'b1;
                    end
                end
                DONE: begin
                    r_lastB <= r_owner;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Outputs decode directly from the registered state and owner
    always_comb begin
        addressSweep = r_addr;
        ownerSweep   = r_owner;
        validSweep   = (r_state == RUN);
        busySweep    = (r_state != IDLE);
        grantA       = busySweep & ~r_owner;
        grantB       = busySweep & r_owner;
        doneA        = (r_state == DONE) & ~r_owner;
        doneB        = (r_state == DONE) & r_owner;
    end

endmodule

// File: tb/tb_sweep_arbiter.sv
// Testbench for sweep_arbiter: a table of one-cycle vectors followed by
// hand-written sequences for the full-range sweep and reset during a sweep.
module tb_sweep_arbiter;

    logic       clockSweep = 1'b0;
    logic       resetSweep;
    logic       reqA, reqB;
    logic [3:0] startA, startB, endA, endB;
    logic       readyIn;
    logic [3:0] addressSweep;
    logic       validSweep, ownerSweep, grantA, grantB, doneA, doneB, busySweep;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic       rstN;
        logic       ra;
        logic       rb;
        logic [3:0] sa;
        logic [3:0] ea;
        logic [3:0] sb;
        logic [3:0] eb;
        logic       rdy;
        logic [10:0] exp;
    } vec_t;

    vec_t vecs[22];

    sweep_arbiter #(.ADDR_WIDTH(4)) dut (
        .clockSweep  (clockSweep),
        .resetSweep  (resetSweep),
        .reqA        (reqA),
        .reqB        (reqB),
        .startA      (startA),
        .startB      (startB),
        .endA        (endA),
        .endB        (endB),
        .readyIn     (readyIn),
        .addressSweep(addressSweep),
        .validSweep  (validSweep),
        .ownerSweep  (ownerSweep),
        .grantA      (grantA),
        .grantB      (grantB),
        .doneA       (doneA),
        .doneB       (doneB),
        .busySweep   (busySweep)
    );

    // Free-running clock
    always #5 clockSweep = ~clockSweep;

    // Packs expected outputs as {addr, valid, owner, grantA, grantB, doneA, doneB, busy}
    function automatic logic [10:0] ex(input logic [3:0] a, input logic v, input logic o,
                                        input logic ga, input logic gb, input logic da,
                                        input logic db, input logic b);
        return {a, v, o, ga, gb, da, db, b};
    endfunction

    function automatic vec_t mk(input logic rstN, input logic ra, input logic rb,
                                input logic [3:0] sa, input logic [3:0] ea,
                                input logic [3:0] sb, input logic [3:0] eb,
                                input logic rdy, input logic [10:0] e);
        vec_t t;
        t.rstN = rstN; t.ra = ra; t.rb = rb;
        t.sa = sa; t.ea = ea; t.sb = sb; t.eb = eb;
        t.rdy = rdy; t.exp = e;
        return t;
    endfunction

    task automatic applyStimulus(input logic rstN, input logic ra, input logic rb,
                                 input logic [3:0] sa, input logic [3:0] ea,
                                 input logic [3:0] sb, input logic [3:0] eb,
                                 input logic rdy);
        resetSweep = rstN;
        reqA = ra; reqB = rb;
        startA = sa; endA = ea;
        startB = sb; endB = eb;
        readyIn = rdy;
    endtask

    task automatic tick();
        @(posedge clockSweep);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [10:0] expv);
        logic [10:0] act;
        act = {addressSweep, validSweep, ownerSweep, grantA, grantB, doneA, doneB, busySweep};
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got addr=%0d v=%b o=%b gA=%b gB=%b dA=%b dB=%b busy=%b, expected addr=%0d v=%b o=%b gA=%b gB=%b dA=%b dB=%b busy=%b",
                     name, act[10:7], act[6], act[5], act[4], act[3], act[2], act[1], act[0],
                     expv[10:7], expv[6], expv[5], expv[4], expv[3], expv[2], expv[1], expv[0]);
        end
    endtask

    task automatic checkValue(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    initial begin
        int  beats;
        bit  doneSeen;

        // Tie from reset, one-beat sweep for A, then B with stalls, then wrapping sweep for A
        vecs[0]  = mk(0,0,0, 0,0, 0,0, 0, ex(0,0,0,0,0,0,0,0));
        vecs[1]  = mk(1,0,0, 0,0, 0,0, 0, ex(0,0,0,0,0,0,0,0));
        vecs[2]  = mk(1,1,1, 7,7, 3,5, 1, ex(7,0,0,1,0,0,0,1));
        vecs[3]  = mk(1,1,1, 2,2, 3,5, 1, ex(7,1,0,1,0,0,0,1));
        vecs[4]  = mk(1,1,1, 2,2, 3,5, 1, ex(7,0,0,1,0,1,0,1));
        vecs[5]  = mk(1,1,1, 2,2, 3,5, 1, ex(7,0,0,0,0,0,0,0));
        vecs[6]  = mk(1,1,1, 2,2, 3,5, 1, ex(3,0,1,0,1,0,0,1));
        vecs[7]  = mk(1,1,0, 2,2, 3,5, 0, ex(3,1,1,0,1,0,0,1));
        vecs[8]  = mk(1,1,0, 2,2, 3,5, 0, ex(3,1,1,0,1,0,0,1));
        vecs[9]  = mk(1,1,0, 2,2, 3,5, 1, ex(4,1,1,0,1,0,0,1));
        vecs[10] = mk(1,1,0, 2,2, 3,5, 0, ex(4,1,1,0,1,0,0,1));
        vecs[11] = mk(1,1,0, 2,2, 3,5, 0, ex(4,1,1,0,1,0,0,1));
        vecs[12] = mk(1,1,0, 2,2, 3,5, 1, ex(5,1,1,0,1,0,0,1));
        vecs[13] = mk(1,1,0, 2,2, 3,5, 1, ex(5,0,1,0,1,0,1,1));
        vecs[14] = mk(1,1,0, 14,1, 3,5, 1, ex(5,0,1,0,0,0,0,0));
        vecs[15] = mk(1,1,0, 14,1, 3,5, 1, ex(14,0,0,1,0,0,0,1));
        vecs[16] = mk(1,0,0, 14,1, 3,5, 1, ex(14,1,0,1,0,0,0,1));
        vecs[17] = mk(1,0,0, 14,1, 3,5, 1, ex(15,1,0,1,0,0,0,1));
        vecs[18] = mk(1,0,0, 14,1, 3,5, 1, ex(0,1,0,1,0,0,0,1));
        vecs[19] = mk(1,0,0, 14,1, 3,5, 1, ex(1,1,0,1,0,0,0,1));
        vecs[20] = mk(1,0,0, 14,1, 3,5, 1, ex(1,0,0,1,0,1,0,1));
        vecs[21] = mk(1,0,0, 14,1, 3,5, 1, ex(1,0,0,0,0,0,0,0));

        applyStimulus(0,0,0, 0,0, 0,0, 0);
        tick();

        for (int i = 0; i < 22; i++) begin
            applyStimulus(vecs[i].rstN, vecs[i].ra, vecs[i].rb, vecs[i].sa, vecs[i].ea,
                          vecs[i].sb, vecs[i].eb, vecs[i].rdy);
            tick();
            checkOutput($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Full-range sweep 0..15 for A with readyIn held high
        applyStimulus(1,1,0, 0,15, 0,0, 1);
        tick();
        checkOutput("fullSetup", ex(0,0,0,1,0,0,0,1));
        applyStimulus(1,0,0, 0,15, 0,0, 1);
        beats = 0;
        doneSeen = 0;
        for (int c = 0; c < 40 && !doneSeen; c++) begin
            tick();
            if (validSweep) begin
                checkValue($sformatf("fullBeat%0d", beats), int'(addressSweep), beats % 16);
                beats++;
            end
            if (doneA) doneSeen = 1;
        end
        checkValue("fullBeatCount", beats, 16);
        checkValue("fullDoneA", int'(doneSeen), 1);
        tick();
        checkOutput("fullIdle", ex(15,0,0,0,0,0,0,0));

        // Reset in the middle of a B sweep at address 9, then a tie must go to A
        applyStimulus(1,0,1, 0,0, 8,12, 1);
        tick();
        checkOutput("midSetup", ex(8,0,1,0,1,0,0,1));
        applyStimulus(1,0,0, 0,0, 8,12, 1);
        tick();
        checkOutput("midRun8", ex(8,1,1,0,1,0,0,1));
        tick();
        checkOutput("midRun9", ex(9,1,1,0,1,0,0,1));
        applyStimulus(0,0,0, 0,0, 8,12, 1);
        tick();
        checkOutput("midReset", ex(0,0,0,0,0,0,0,0));
        applyStimulus(1,1,1, 2,2, 4,4, 1);
        tick();
        checkOutput("postResetTie", ex(2,0,0,1,0,0,0,1));
        applyStimulus(1,0,0, 2,2, 4,4, 1);
        tick();
        checkOutput("postResetRun", ex(2,1,0,1,0,0,0,1));
        tick();
        checkOutput("postResetDone", ex(2,0,0,1,0,1,0,1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
